// File: rtl/spi_flash_pkg.sv
// Shared types and defaults for the SPI flash read sequencer.
package spi_flash_pkg;

    // Standard serial-flash READ opcode (no dummy cycles).
    localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

    // Two-byte SPI word as seen by the byte engine; index [1] goes out first.
    typedef logic [1:0][7:0] spi_word_t;

    typedef enum logic [3:0] {
        IDLE,
        CMD_HI,
        CMD_HI_W,
        CMD_LO,
        CMD_LO_W,
        RD_REQ,
        RD_W,
        OUT1,
        OUT0
    } state_t;

    // States in which a transfer request is being offered to the engine.
    function automatic logic is_flash_req(input state_t st);
        return (st == CMD_HI) || (st == CMD_LO) || (st == RD_REQ);
    endfunction

    // States in which a byte is being offered downstream.
    function automatic logic is_stream_out(input state_t st);
        return (st == OUT1) || (st == OUT0);
    endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// Read-command sequencer in front of the spi_flash byte engine: sends
// READ + 24-bit address, then pulls data two bytes at a time and streams
// it out on a ready/valid byte interface. CS stays low for the whole
// request and is released with the final read transfer.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter int         SIZE_BITS = 16,
    parameter logic [7:0] READ_CMD  = READ_CMD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [23:0]          s_addr,
    input  logic [SIZE_BITS-1:0] s_size,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [7:0]           m_data,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 flash_last,
    output logic                 flash_len,
    output logic [1:0][7:0]      flash_wdata,
    output logic                 flash_valid,
    input  logic                 flash_ready,
    input  logic [1:0][7:0]      flash_rdata,
    input  logic                 flash_rvalid
);

    // One extra bit so that s_size = all-ones (2^SIZE_BITS bytes) fits.
    typedef logic [SIZE_BITS:0] remain_t;

    state_t    state_reg,  state_next;
    logic [23:0] addr_reg, addr_next;
    remain_t   remain_reg, remain_next;
    spi_word_t rdata_reg,  rdata_next;

    // All outputs are registered so they are glitch-free and only move on
    // a clock edge; their next values are decoded from the next state.
    logic      s_ready_reg,     s_ready_next;
    logic      busy_reg,        busy_next;
    logic      m_valid_reg,     m_valid_next;
    logic      m_last_reg,      m_last_next;
    logic [7:0] m_data_reg,     m_data_next;
    logic      flash_valid_reg, flash_valid_next;
    logic      flash_last_reg,  flash_last_next;
    logic      flash_len_reg,   flash_len_next;
    spi_word_t flash_wdata_reg, flash_wdata_next;

    logic req_accept;
    logic flash_accept;
    logic out_accept;

    assign req_accept   = s_valid && s_ready_reg;
    assign flash_accept = flash_valid_reg && flash_ready;
    assign out_accept   = m_valid_reg && m_ready;

    // State, datapath and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            remain_reg      <= '0;
            rdata_reg       <= '0;
            s_ready_reg     <= 1'b1;
            busy_reg        <= 1'b0;
            m_valid_reg     <= 1'b0;
            m_last_reg      <= 1'b0;
            m_data_reg      <= '0;
            flash_valid_reg <= 1'b0;
            flash_last_reg  <= 1'b0;
            flash_len_reg   <= 1'b0;
            flash_wdata_reg <= '0;
        end else begin
            state_reg       <= state_next;
            addr_reg        <= addr_next;
            remain_reg      <= remain_next;
            rdata_reg       <= rdata_next;
            s_ready_reg     <= s_ready_next;
            busy_reg        <= busy_next;
            m_valid_reg     <= m_valid_next;
            m_last_reg      <= m_last_next;
            m_data_reg      <= m_data_next;
            flash_valid_reg <= flash_valid_next;
            flash_last_reg  <= flash_last_next;
            flash_len_reg   <= flash_len_next;
            flash_wdata_reg <= flash_wdata_next;
        end
    end

    // Next-state and datapath update: sequencing of command, read and output phases.
    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        remain_next = remain_reg;
        rdata_next  = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_accept) begin
                    addr_next   = s_addr;
                    remain_next = {1'b0, s_size} + remain_t'(1);
                    state_next  = CMD_HI;
                end
            end
            CMD_HI: begin
                if (flash_accept) state_next = CMD_HI_W;
            end
            CMD_HI_W: begin
                // Bytes clocked back during the command phase are meaningless.
                if (flash_rvalid) state_next = CMD_LO;
            end
            CMD_LO: begin
                if (flash_accept) state_next = CMD_LO_W;
            end
            CMD_LO_W: begin
                if (flash_rvalid) state_next = RD_REQ;
            end
            RD_REQ: begin
                if (flash_accept) state_next = RD_W;
            end
            RD_W: begin
                if (flash_rvalid) begin
                    rdata_next = flash_rdata;
                    // A single-byte transfer returns its byte in [0].
                    state_next = (remain_reg >= remain_t'(2)) ? OUT1 : OUT0;
                end
            end
            OUT1: begin
                if (out_accept) begin
                    remain_next = remain_reg - remain_t'(1);
                    state_next  = OUT0;
                end
            end
            OUT0: begin
                if (out_accept) begin
                    remain_next = remain_reg - remain_t'(1);
                    // Next read is only issued once both buffered bytes are gone.
                    state_next  = (remain_reg == remain_t'(1)) ? IDLE : RD_REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the next state, so registered outputs line up with state_reg.
    always_comb begin
        s_ready_next     = (state_next == IDLE);
        busy_next        = (state_next != IDLE);
        flash_valid_next = is_flash_req(state_next);
        flash_len_next   = 1'b0;
        flash_last_next  = 1'b0;
        flash_wdata_next = '0;
        m_valid_next     = is_stream_out(state_next);
        m_last_next      = 1'b0;
        m_data_next      = '0;
        case (state_next)
            CMD_HI: begin
                flash_len_next   = 1'b1;
                flash_wdata_next = {READ_CMD, addr_next[23:16]};
            end
            CMD_LO: begin
                flash_len_next   = 1'b1;
                flash_wdata_next = {addr_next[15:8], addr_next[7:0]};
            end
            RD_REQ: begin
                // Dummy MOSI bytes; CS is released only with the final pair.
                flash_len_next  = (remain_next >= remain_t'(2));
                flash_last_next = (remain_next <= remain_t'(2));
            end
            OUT1: begin
                m_data_next = rdata_next[1];
            end
            OUT0: begin
                m_data_next = rdata_next[0];
                m_last_next = (remain_next == remain_t'(1));
            end
            default: begin
            end
        endcase
    end

    assign s_ready     = s_ready_reg;
    assign busy        = busy_reg;
    assign m_valid     = m_valid_reg;
    assign m_last      = m_last_reg;
    assign m_data      = m_data_reg;
    assign flash_valid = flash_valid_reg;
    assign flash_last  = flash_last_reg;
    assign flash_len   = flash_len_reg;
    assign flash_wdata = flash_wdata_reg;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a behavioural byte-engine/flash model answers
// transfer requests; MOSI bytes, transfer framing and the output stream
// are compared against hand-derived expectations.
module tb_spi_flash_reader;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [23:0]      s_addr;
    logic [15:0]      s_size;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       m_data;
    logic             m_last;
    logic             m_valid;
    logic             m_ready;
    logic             busy;
    logic             flash_last;
    logic             flash_len;
    logic [1:0][7:0]  flash_wdata;
    logic             flash_valid;
    logic             flash_ready;
    logic [1:0][7:0]  flash_rdata;
    logic             flash_rvalid;

    always #5 clk = ~clk;

    spi_flash_reader #(.SIZE_BITS(16), .READ_CMD(8'h03)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_addr       (s_addr),
        .s_size       (s_size),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .busy         (busy),
        .flash_last   (flash_last),
        .flash_len    (flash_len),
        .flash_wdata  (flash_wdata),
        .flash_valid  (flash_valid),
        .flash_ready  (flash_ready),
        .flash_rdata  (flash_rdata),
        .flash_rvalid (flash_rvalid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] fmem(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Model and scoreboard state
    logic [7:0] mosi_q[$];
    logic       xlen_q[$];
    logic       xlast_q[$];
    logic [7:0] out_d_q[$];
    logic       out_l_q[$];
    int         cs_rises;
    int         ready_mode;
    int         frame_pos;
    logic [23:0] frame_addr;
    int         cnt;
    logic [1:0][7:0] resp;

    // Flash engine model + output monitor: observe at negedge, drive at posedge+1.
    initial begin
        logic f_hs, f_len, f_last, o_hs, o_l, stall_prev, stall_l, sready_watch;
        logic [1:0][7:0] f_wd;
        logic [7:0] o_d, stall_d, b, r;
        int phase, nb;
        flash_ready = 1'b1; flash_rvalid = 1'b0; flash_rdata = '0; m_ready = 1'b1;
        cnt = 0; frame_pos = 0; frame_addr = '0; cs_rises = 0; resp = '0;
        stall_prev = 0; stall_d = '0; stall_l = 0; sready_watch = 0; phase = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 0;
                sready_watch = 0;
            end else begin
                if (sready_watch) begin
                    chk("s_ready_rise", s_ready, 1);
                    sready_watch = 0;
                end
                if (stall_prev) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data", m_data, stall_d);
                    chk("hold_last", m_last, stall_l);
                end
            end
            f_hs = reset_n && flash_valid && flash_ready;
            f_len = flash_len; f_last = flash_last; f_wd = flash_wdata;
            o_hs = reset_n && m_valid && m_ready;
            o_d = m_data; o_l = m_last;
            stall_prev = reset_n && m_valid && !m_ready;
            stall_d = m_data; stall_l = m_last;
            if (o_hs) begin
                out_d_q.push_back(o_d);
                out_l_q.push_back(o_l);
                if (o_l) begin
                    chk("s_ready_low_at_last", s_ready, 0);
                    sready_watch = 1;
                end
            end
            @(posedge clk);
            #1;
            flash_rvalid = 1'b0;
            if (!reset_n) begin
                cnt = 0;
                frame_pos = 0;
                flash_ready = 1'b1;
            end else if (f_hs) begin
                nb = f_len ? 2 : 1;
                resp = '0;
                for (int k = 0; k < nb; k++) begin
                    b = (k == 0) ? f_wd[1] : f_wd[0];
                    mosi_q.push_back(b);
                    if (frame_pos == 1) frame_addr[23:16] = b;
                    else if (frame_pos == 2) frame_addr[15:8] = b;
                    else if (frame_pos == 3) frame_addr[7:0] = b;
                    r = (frame_pos >= 4) ? fmem(frame_addr + 24'(frame_pos - 4)) : 8'hEE;
                    if (nb == 1) begin
                        resp[0] = r;
                        resp[1] = 8'hEE;
                    end else if (k == 0) resp[1] = r;
                    else resp[0] = r;
                    frame_pos++;
                end
                xlen_q.push_back(f_len);
                xlast_q.push_back(f_last);
                if (f_last) begin
                    cs_rises++;
                    frame_pos = 0;
                end
                flash_ready = 1'b0;
                cnt = 3;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    flash_rvalid = 1'b1;
                    flash_rdata = resp;
                    flash_ready = 1'b1;
                end
            end
            if (ready_mode == 0) m_ready = 1'b1;
            else begin
                m_ready = (phase == 0);
                phase = (phase + 1) % 4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        mosi_q.delete(); xlen_q.delete(); xlast_q.delete();
        out_d_q.delete(); out_l_q.delete();
        cs_rises = 0;
    endtask

    // One read request, then compare MOSI, framing and the byte stream.
    task automatic run_req(input logic [23:0] addr, input int size, input int mode, input bit poke);
        int n, nx, guard;
        logic [7:0] exp_b;
        n = size + 1;
        nx = (n + 1) / 2;
        clear_logs();
        ready_mode = mode;
        chk("s_ready_idle_before", s_ready, 1);
        s_addr = addr; s_size = size[15:0]; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_addr = '0; s_size = '0;
        chk("busy_after_accept", busy, 1);
        chk("s_ready_after_accept", s_ready, 0);
        if (poke) begin
            repeat (3) tick();
            chk("s_ready_while_busy", s_ready, 0);
            s_addr = 24'hFFFFFF; s_size = 16'd7; s_valid = 1'b1;
            tick();
            s_valid = 1'b0; s_addr = '0; s_size = '0;
        end
        guard = 0;
        while (out_d_q.size() < n && guard < 4000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 4000) chk("stream_timeout", 0, 1);
        repeat (6) tick();
        chk("n_bytes", out_d_q.size(), n);
        for (int i = 0; i < n && i < out_d_q.size(); i++) begin
            chk($sformatf("byte%0d", i), out_d_q[i], fmem(addr + 24'(i)));
            chk($sformatf("last%0d", i), out_l_q[i], (i == n - 1));
        end
        chk("mosi_count", mosi_q.size(), 4 + n);
        for (int i = 0; i < mosi_q.size() && i < 4 + n; i++) begin
            case (i)
                0: exp_b = 8'h03;
                1: exp_b = addr[23:16];
                2: exp_b = addr[15:8];
                3: exp_b = addr[7:0];
                default: exp_b = 8'h00;
            endcase
            chk($sformatf("mosi%0d", i), mosi_q[i], exp_b);
        end
        chk("cs_rises", cs_rises, 1);
        chk("xfer_count", xlen_q.size(), 2 + nx);
        for (int j = 0; j < xlen_q.size() && j < 2 + nx; j++) begin
            if (j < 2) begin
                chk($sformatf("cmd_len%0d", j), xlen_q[j], 1);
                chk($sformatf("cmd_last%0d", j), xlast_q[j], 0);
            end else begin
                chk($sformatf("rd_len%0d", j - 2), xlen_q[j], ((j - 2 < nx - 1) || (n % 2 == 0)));
                chk($sformatf("rd_last%0d", j - 2), xlast_q[j], (j - 2 == nx - 1));
            end
        end
        chk("s_ready_idle_after", s_ready, 1);
        chk("busy_idle_after", busy, 0);
        $display("req addr=%06h size=%0d bytes=%0d xfers=%0d", addr, size, out_d_q.size(), xlen_q.size());
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_s_ready"}, s_ready, 1);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_m_valid"}, m_valid, 0);
        chk({pfx, "_m_last"}, m_last, 0);
        chk({pfx, "_m_data"}, m_data, 0);
        chk({pfx, "_flash_valid"}, flash_valid, 0);
        chk({pfx, "_flash_last"}, flash_last, 0);
        chk({pfx, "_flash_len"}, flash_len, 0);
        chk({pfx, "_flash_wdata"}, flash_wdata, 0);
    endtask

    initial begin
        int guard;
        reset_n = 1'b0; s_valid = 1'b0; s_addr = '0; s_size = '0; ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        #2 reset_n = 1'b1;
        repeat (2) tick();

        run_req(24'h012345, 3, 0, 0);
        run_req(24'h000010, 0, 0, 0);
        run_req(24'h000200, 4, 0, 0);
        run_req(24'h000300, 7, 1, 0);

        // Abort a size=15 request while its first read transfer is in flight.
        clear_logs();
        ready_mode = 0;
        s_addr = 24'h000100; s_size = 16'd15; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_addr = '0; s_size = '0;
        guard = 0;
        while (xlen_q.size() < 3 && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 200) chk("rd_w_timeout", 0, 1);
        #1 reset_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (10) tick();
        chk("no_resume_bytes", out_d_q.size(), 0);
        chk("no_resume_valid", m_valid, 0);
        $display("reset during RD_W: xfers before reset=%0d", xlen_q.size());

        run_req(24'h000000, 1, 0, 0);
        run_req(24'h000400, 2, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
